// File: rtl/bsearch_pkg.sv
// bsearch_pkg: FSM state encoding, search-mode constants and width helpers
// shared by the binary-search engine, its datapath and its interface.
package bsearch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    COMPARE,
    RESOLVE,
    DONE
  } state_t;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_LOWER = 1'b1;

  // Read-latency counter width; one bit minimum so RD_LAT=1 still elaborates.
  function automatic int wait_cnt_w(input int rd_lat);
    return (rd_lat > 1) ? $clog2(rd_lat) : 1;
  endfunction

  // Probe counter width: must hold up to ADDR_W+1 probes.
  function automatic int probe_cnt_w(input int addr_w);
    return $clog2(addr_w + 2);
  endfunction

endpackage

// File: rtl/bsearch_engine_if.sv
// bsearch_engine_if: request/result handshake plus the synchronous RAM read
// port of the binary-search engine. The slave side is the engine; the master
// side is the controlling logic together with the array RAM.
// Optional macro BSEARCH_PROBE_CNT_EN adds the probes result field.
interface bsearch_engine_if
  import bsearch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);

  // Request side
  logic              start;
  logic              mode;
  logic [DATA_W-1:0] target;

  // Array RAM read port
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // Result side
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W-1:0] loc;

`ifdef BSEARCH_PROBE_CNT_EN
  logic [probe_cnt_w(ADDR_W)-1:0] probes;

  modport master (
    output start, mode, target, rd_data,
    input  rd_en, rd_addr, busy, done, found, loc, probes
  );

  modport slave (
    input  start, mode, target, rd_data,
    output rd_en, rd_addr, busy, done, found, loc, probes
  );
`else
  modport master (
    output start, mode, target, rd_data,
    input  rd_en, rd_addr, busy, done, found, loc
  );

  modport slave (
    input  start, mode, target, rd_data,
    output rd_en, rd_addr, busy, done, found, loc
  );
`endif

endinterface

// File: rtl/bsearch_dp.sv
// bsearch_dp: search-interval datapath. Holds the half-open interval [lo, hi),
// the captured target and the last probed value that moved hi (cand), and
// performs the single unsigned compare per probe.
module bsearch_dp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_i,        // start accepted: reset interval
  input  logic              cmp_i,         // rd_data_i is valid this cycle
  input  logic [DATA_W-1:0] target_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [ADDR_W-1:0] lo_o,
  output logic [ADDR_W-1:0] mid_o,
  output logic              lo_lt_hi_o,
  output logic              hi_at_depth_o,
  output logic              cand_eq_tgt_o
);

  // lo/hi need one extra bit: hi starts at DEPTH, which may be 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W:0]   lo_q, lo_d;
  logic [ADDR_W:0]   hi_q, hi_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic [DATA_W-1:0] cand_q, cand_d;
  logic [ADDR_W:0]   sum;
  logic [ADDR_W:0]   mid;
  logic              rd_lt_tgt;

  // lo+hi never exceeds 2*DEPTH-1 while lo<hi, so ADDR_W+1 bits suffice.
  assign sum       = lo_q + hi_q;
  assign mid       = sum >> 1;
  assign rd_lt_tgt = (rd_data_i < tgt_q);

  // Next interval: restart on accept, otherwise narrow on each compare.
  always_comb begin
    // NOTE: every signal written here is defaulted first, so no path through
    // the block can hold a stale value and infer a latch.
    lo_d   = lo_q;
    hi_d   = hi_q;
    tgt_d  = tgt_q;
    cand_d = cand_q;
    if (init_i) begin
      lo_d   = '0;
      hi_d   = DEPTH_V;
      tgt_d  = target_i;
      cand_d = '0;
    end else if (cmp_i) begin
      if (rd_lt_tgt) begin
        lo_d = mid + (ADDR_W + 1)'(1);
      end else begin
        hi_d   = mid;
        cand_d = rd_data_i;
      end
    end
  end

  // Interval, target and candidate registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      lo_q   <= '0;
      hi_q   <= '0;
      tgt_q  <= '0;
      cand_q <= '0;
    end else begin
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      tgt_q  <= tgt_d;
      cand_q <= cand_d;
    end
  end

  // mid < hi <= DEPTH <= 2**ADDR_W, so the low ADDR_W bits are the address.
  // lo reaches DEPTH only when hi == DEPTH, where loc is forced to 0.
  assign mid_o         = mid[ADDR_W-1:0];
  assign lo_o          = lo_q[ADDR_W-1:0];
  assign lo_lt_hi_o    = (lo_q < hi_q);
  assign hi_at_depth_o = (hi_q == DEPTH_V);
  assign cand_eq_tgt_o = (cand_q == tgt_q);

endmodule

// File: rtl/bsearch_engine.sv
// bsearch_engine: binary search over an external sorted array through a
// synchronous read port of configurable latency. Exact-match and lower-bound
// modes; all outputs registered. Optional macro BSEARCH_PROBE_CNT_EN adds a
// probe counter reported on the interface.
module bsearch_engine
  import bsearch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  bsearch_engine_if.slave  bus
);

  localparam int CNT_W = wait_cnt_w(RD_LAT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              found_q, found_d;
  logic [ADDR_W-1:0] loc_q, loc_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic              dp_init;
  logic              dp_cmp;
  logic [ADDR_W-1:0] dp_lo;
  logic [ADDR_W-1:0] dp_mid;
  logic              dp_lo_lt_hi;
  logic              dp_hi_at_depth;
  logic              dp_cand_eq;

  bsearch_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_dp (
    .clk           (clk),
    .reset         (reset),
    .init_i        (dp_init),
    .cmp_i         (dp_cmp),
    .target_i      (bus.target),
    .rd_data_i     (bus.rd_data),
    .lo_o          (dp_lo),
    .mid_o         (dp_mid),
    .lo_lt_hi_o    (dp_lo_lt_hi),
    .hi_at_depth_o (dp_hi_at_depth),
    .cand_eq_tgt_o (dp_cand_eq)
  );

  // Next state and registered-output values for the search sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    busy_d    = busy_q;
    done_d    = done_q;
    found_d   = found_q;
    loc_d     = loc_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    dp_init   = 1'b0;
    dp_cmp    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          busy_d  = 1'b1;
          found_d = 1'b0;
          loc_d   = '0;
          dp_init = 1'b1;
          state_d = CHECK;
        end
      end

      CHECK: begin
        // rd_en is registered, so it is raised here to be high during ISSUE.
        if (dp_lo_lt_hi) begin
          rd_en_d   = 1'b1;
          rd_addr_d = dp_mid;
          state_d   = ISSUE;
        end else begin
          state_d = RESOLVE;
        end
      end

      ISSUE: begin
        cnt_d = CNT_W'(RD_LAT - 1);
        if (RD_LAT == 1) begin
          state_d = COMPARE;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        dp_cmp  = 1'b1;
        state_d = CHECK;
      end

      RESOLVE: begin
        if (dp_hi_at_depth) begin
          // No entry >= target: nothing to report in either mode.
          found_d = 1'b0;
          loc_d   = '0;
        end else if (mode_q == MODE_LOWER) begin
          found_d = 1'b1;
          loc_d   = dp_lo;
        end else begin
          // lo is the first index >= target, so it is also the lowest match.
          found_d = dp_cand_eq;
          loc_d   = dp_cand_eq ? dp_lo : '0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end

      DONE: begin
        // A held start never retriggers; the requester must drop it first.
        if (!bus.start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, wait counter and registered outputs; reset aborts any search.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= MODE_EXACT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      loc_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      found_q   <= found_d;
      loc_q     <= loc_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

`ifdef BSEARCH_PROBE_CNT_EN
  localparam int PROBE_W = probe_cnt_w(ADDR_W);

  logic [PROBE_W-1:0] probe_q, probe_d;

  // Probe counter: cleared on accept, bumped once per issued read.
  always_comb begin
    probe_d = probe_q;
    if (state_q == IDLE && bus.start) begin
      probe_d = '0;
    end else if (state_q == ISSUE) begin
      probe_d = probe_q + PROBE_W'(1);
    end
  end

  // Probe counter register; holds its value through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      probe_q <= '0;
    end else begin
      probe_q <= probe_d;
    end
  end

  assign bus.probes = probe_q;
`else
  // Probe counting disabled: no counter and no probes field.
`endif

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.found   = found_q;
  assign bus.loc     = loc_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;

endmodule

// File: tb/tb_bsearch_engine.sv
// tb_bsearch_engine: two engines (read latency 1 and 3) over behavioural
// RAMs. Directed searches push hand-computed results into per-instance
// queues; a monitor per instance pops and compares on each rising done.
module tb_bsearch_engine;
  import bsearch_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 3;
  localparam int P_MAX  = 6;   // floor(log2(32)) + 1

  typedef struct packed {
    logic              found;
    logic [ADDR_W-1:0] loc;
  } res_t;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              found;
    logic              rd_en;
    logic [ADDR_W-1:0] loc;
    logic [ADDR_W-1:0] rd_addr;
  } obs_t;

  logic clk = 1'b0;
  logic reset;

  int   checks = 0;
  int   errors = 0;
  res_t sb_a[$];
  res_t sb_b[$];
  int   rises[2];
  int   last_rd[2];
  obs_t obs[2];

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [DATA_W-1:0] pipe_a_d [LAT_A];
  logic              pipe_a_v [LAT_A];
  logic [DATA_W-1:0] pipe_b_d [LAT_B];
  logic              pipe_b_v [LAT_B];

  always #5 clk = ~clk;

  bsearch_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_a ();
  bsearch_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_b ();

  bsearch_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(LAT_A))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));

  bsearch_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(LAT_B))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));

  // Behavioural RAMs: data is presented only in the cycle exactly RD_LAT
  // edges after rd_en, and reads as 0 in every other cycle.
  always @(posedge clk) begin
    pipe_a_d[0] <= mem_a[if_a.rd_addr];
    pipe_a_v[0] <= if_a.rd_en;
    for (int k = 1; k < LAT_A; k++) begin
      pipe_a_d[k] <= pipe_a_d[k-1];
      pipe_a_v[k] <= pipe_a_v[k-1];
    end
    pipe_b_d[0] <= mem_b[if_b.rd_addr];
    pipe_b_v[0] <= if_b.rd_en;
    for (int k = 1; k < LAT_B; k++) begin
      pipe_b_d[k] <= pipe_b_d[k-1];
      pipe_b_v[k] <= pipe_b_v[k-1];
    end
  end

  assign if_a.rd_data = pipe_a_v[LAT_A-1] ? pipe_a_d[LAT_A-1] : '0;
  assign if_b.rd_data = pipe_b_v[LAT_B-1] ? pipe_b_d[LAT_B-1] : '0;

  assign obs[0] = {if_a.busy, if_a.done, if_a.found, if_a.rd_en, if_a.loc, if_a.rd_addr};
  assign obs[1] = {if_b.busy, if_b.done, if_b.found, if_b.rd_en, if_b.loc, if_b.rd_addr};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int inst, input logic s, input logic m, input logic [DATA_W-1:0] t);
    if (inst == 0) begin
      if_a.start = s; if_a.mode = m; if_a.target = t;
    end else begin
      if_b.start = s; if_b.mode = m; if_b.target = t;
    end
  endtask

  // Monitor: on each rising done, pop the expected result and compare.
  task automatic monitor(input int inst);
    logic done_prev = 1'b0;
    logic rd_prev   = 1'b0;
    logic dbl       = 1'b0;
    int   rd_cnt    = 0;
    int   pending;
    res_t e;
    obs_t o;
    forever begin
      @(negedge clk);
      o = obs[inst];
      if (reset) begin
        done_prev = 1'b0; rd_prev = 1'b0; dbl = 1'b0; rd_cnt = 0;
      end else begin
        if (o.rd_en) rd_cnt++;
        if (o.rd_en && rd_prev) dbl = 1'b1;
        if (o.done && !done_prev) begin
          rises[inst]++;
          last_rd[inst] = rd_cnt;
          check($sformatf("m%0d_rd_en_single_cycle", inst), 32'(dbl), 0);
          rd_cnt = 0;
          dbl    = 1'b0;
          pending = (inst == 0) ? sb_a.size() : sb_b.size();
          if (pending == 0) begin
            checks++;
            errors++;
            $display("FAIL m%0d_unexpected_done: got a result with none pending", inst);
          end else begin
            if (inst == 0) e = sb_a.pop_front();
            else           e = sb_b.pop_front();
            check($sformatf("m%0d_found", inst), 32'(o.found), 32'(e.found));
            check($sformatf("m%0d_loc", inst), 32'(o.loc), 32'(e.loc));
          end
        end
        done_prev = o.done;
        rd_prev   = o.rd_en;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // One search: queue the expectation, hold start until done (bounded),
  // scribble target/mode while busy, hold start 'hold' extra cycles, release.
  task automatic run_search(input int inst, input logic m, input logic [DATA_W-1:0] t,
                            input logic ef, input logic [ADDR_W-1:0] el,
                            input int hold, input string name);
    int   n;
    int   limit;
    int   r0;
    logic got;
    obs_t o;
    limit = 2 + P_MAX * (((inst == 0) ? LAT_A : LAT_B) + 2);
    r0    = rises[inst];
    if (inst == 0) sb_a.push_back({ef, el});
    else           sb_b.push_back({ef, el});
    @(negedge clk);
    drive(inst, 1'b1, m, t);
    n   = 0;
    got = 1'b0;
    while (!got && n < limit + 2) begin
      @(negedge clk);
      n++;
      if (n == 1) drive(inst, 1'b1, ~m, ~t);
      got = obs[inst].done;
    end
    check({name, "_done_in_time"}, 32'(got && ((n - 1) <= limit)), 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      o = obs[inst];
      check({name, "_held_done_idle"}, 32'({o.done, o.busy}), 2);
    end
    drive(inst, 1'b0, m, t);
    @(negedge clk);
    o = obs[inst];
    check({name, "_done_dropped"}, 32'(o.done), 0);
    check({name, "_found_kept"}, 32'(o.found), 32'(ef));
    check({name, "_loc_kept"}, 32'(o.loc), 32'(el));
    check({name, "_single_result"}, rises[inst] - r0, 1);
  endtask

  initial begin
    obs_t o;
    reset = 1'b1;
    drive(0, 1'b0, MODE_EXACT, '0);
    drive(1, 1'b0, MODE_EXACT, '0);
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = DATA_W'(2 * i + 1);
      mem_b[i] = DATA_W'(2 * i + 1);
    end
    repeat (3) @(negedge clk);

    o = obs[0];
    check("rst_busy", 32'(o.busy), 0);
    check("rst_done", 32'(o.done), 0);
    check("rst_found", 32'(o.found), 0);
    check("rst_rd_en", 32'(o.rd_en), 0);
    check("rst_loc", 32'(o.loc), 0);
    check("rst_rd_addr", 32'(o.rd_addr), 0);
    o = obs[1];
    check("rst_b_busy", 32'(o.busy), 0);
    check("rst_b_done", 32'(o.done), 0);
`ifdef BSEARCH_PROBE_CNT_EN
    check("rst_probes", 32'(if_a.probes), 0);
`endif
    reset = 1'b0;

    // Odd array 1,3,...,63 with RD_LAT=1.
    run_search(0, MODE_EXACT, 8'd21, 1'b1, 5'd10, 0, "a_exact_21");
    check("a_exact_21_rd_pulses_le6", 32'(last_rd[0] <= 6), 1);
`ifdef BSEARCH_PROBE_CNT_EN
    check("a_exact_21_probes", 32'(if_a.probes), 5);
`endif
    run_search(0, MODE_EXACT, 8'd20, 1'b0, 5'd0,  0, "a_exact_20");
    run_search(0, MODE_LOWER, 8'd20, 1'b1, 5'd10, 0, "a_lower_20");
    run_search(0, MODE_LOWER, 8'd64, 1'b0, 5'd0,  0, "a_lower_64");
    run_search(0, MODE_LOWER, 8'd0,  1'b1, 5'd0,  0, "a_lower_0");
    run_search(0, MODE_EXACT, 8'd63, 1'b1, 5'd31, 0, "a_exact_63");

    // All-duplicate array: lowest matching index wins.
    for (int i = 0; i < DEPTH; i++) mem_a[i] = 8'd7;
    run_search(0, MODE_EXACT, 8'd7, 1'b1, 5'd0, 0, "a_dup_exact_7");
    run_search(0, MODE_EXACT, 8'd8, 1'b0, 5'd0, 0, "a_dup_exact_8");
    run_search(0, MODE_LOWER, 8'd6, 1'b1, 5'd0, 0, "a_dup_lower_6");

    // RD_LAT=3 instance.
    run_search(1, MODE_EXACT, 8'd63, 1'b1, 5'd31, 0, "b_exact_63");
    run_search(1, MODE_EXACT, 8'd1,  1'b1, 5'd0,  0, "b_exact_1");
    run_search(1, MODE_LOWER, 8'd62, 1'b1, 5'd31, 0, "b_lower_62");
    run_search(1, MODE_EXACT, 8'd2,  1'b0, 5'd0,  0, "b_exact_2");

    // Reset four cycles into a search aborts it without a result.
    for (int i = 0; i < DEPTH; i++) mem_a[i] = DATA_W'(2 * i + 1);
    @(negedge clk);
    drive(0, 1'b1, MODE_EXACT, 8'd21);
    repeat (4) @(negedge clk);
    check("abort_busy_before", 32'(obs[0].busy), 1);
    reset = 1'b1;
    @(negedge clk);
    o = obs[0];
    check("abort_busy", 32'(o.busy), 0);
    check("abort_done", 32'(o.done), 0);
    check("abort_rd_en", 32'(o.rd_en), 0);
    reset = 1'b0;
    drive(0, 1'b0, MODE_EXACT, 8'd21);
    run_search(0, MODE_EXACT, 8'd1, 1'b1, 5'd0, 0, "a_after_abort_1");

    // start held high for 10 cycles after done: one result, done held.
    run_search(0, MODE_EXACT, 8'd21, 1'b1, 5'd10, 10, "a_hold_21");
`ifdef BSEARCH_PROBE_CNT_EN
    check("a_hold_21_probes", 32'(if_a.probes), 5);
`endif

    repeat (2) @(negedge clk);
    check("sb_a_drained", sb_a.size(), 0);
    check("sb_b_drained", sb_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
